comb_always_rr_select: RTL and testbench
========================================

Name: comb_always_rr_select

Overview:
- Parametrised successor to the combinational case/if selectors.
- Arbitrates NUM_CH valid/ready input channels onto one registered output using round-robin priority.
- Holds the selected word in a single output register stage.
- Sits between multiple producers and one consumer. Used as the first sequential-always elaboration target in the stage-14 set.

Parameters:
- NUM_CH, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data bits per channel.
- SEL_W, $clog2(NUM_CH), width of the channel index. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  NUM_CH  per-channel valid; bit k belongs to channel k
- in_data  input  NUM_CH*WIDTH  packed data; channel k occupies [k*WIDTH +: WIDTH]
- in_ready  output  NUM_CH  per-channel accept, one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected word
- out_sel  output  SEL_W  index of the channel that produced out_data
- out_ready  input  1  consumer accept

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst is high.
- Transfer definitions:
  - Input transfer on channel k: in_valid[k] & in_ready[k].
  - Output transfer: out_valid & out_ready.
- load = !out_valid | out_ready. The register is empty or being drained this cycle.
- Grant (combinational):
  - Search channels ptr, ptr+1, ..., wrapping modulo NUM_CH.
  - First channel with in_valid=1 wins.
  - in_ready[k] = load & grant[k].
  - At most one in_ready bit is high.
- On a clock edge with load=1 and a grant to channel k:
  - out_data <= in_data[k].
  - out_sel <= k.
  - out_valid <= 1.
  - ptr <= (k+1) mod NUM_CH. Wraps from NUM_CH-1 to 0.
- On a clock edge with load=1 and no in_valid bits set:
  - out_valid <= 0.
  - out_data, out_sel and ptr hold.
- Stall (out_valid=1 & out_ready=0):
  - out_data, out_sel and ptr stable.
  - in_ready all 0.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 word/cycle with out_ready held high (simultaneous drain and load).
- in_valid changes on non-granted channels never disturb the output register.
- ptr advances only on an input transfer.
- No combinational path from out_ready to out_data. A path from out_ready to in_ready is permitted.
- Reset asserted mid-stall drops the held word. No transfer occurs in the reset cycle.

Optional Feature:
- Macro: COMB_ALWAYS_RR_LOCK_EN.
- Defined:
  - Adds port in_last, input, NUM_CH, marking the final beat of a packet.
  - After a grant to channel k with in_last[k]=0, the block enters LOCKED(k) and keeps granting k, ignoring other valids, until a transfer with in_last[k]=1. It then returns to IDLE and sets ptr=(k+1) mod NUM_CH.
  - While LOCKED, ptr holds.
  - in_valid[k]=0 in LOCKED yields no grant; the lock persists.
  - Reset returns to IDLE.
- Undefined:
  - No in_last port.
  - Arbitration is per beat as described above.

Test Plan:
1. Reset with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0; after release, first grant goes to channel 0.
2. NUM_CH=4, all channels valid with data 0x10,0x11,0x12,0x13, out_ready=1 -> out_sel sequence 0,1,2,3,0, one word per cycle, out_data matches the channel.
3. Only channel 3 valid, then only channel 1 valid -> grants 3 then 1; ptr wraps to 0 after the channel-3 grant and to 2 after channel 1.
4. out_valid=1 with out_ready=0 for 3 cycles while all channels are valid -> out_data/out_sel stable and in_ready=0 throughout; on release, next grant is ptr (the channel after the held one).
5. Async rst pulse mid-stall, between clock edges -> out_valid drops to 0 immediately; ptr=0 after release.
6. With COMB_ALWAYS_RR_LOCK_EN: channel 2 sends 3 beats (in_last=0,0,1) while channels 0 and 1 are valid -> out_sel=2 for 3 beats, then grant goes to channel 3 if valid, else channel 0.

Source files
------------

// File: rtl/comb_always_rr_select.sv
// Round-robin arbiter: NUM_CH valid/ready producers onto one registered output stage.
// Define COMB_ALWAYS_RR_LOCK_EN to add in_last and hold a grant until a packet's final beat.
module comb_always_rr_select #(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
`ifdef COMB_ALWAYS_RR_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last,
`endif
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] grant_idx, next_idx;
  logic [WIDTH-1:0] grant_data;
  logic             grant_any, load, xfer;

`ifdef COMB_ALWAYS_RR_LOCK_EN
  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;
  state_e           state_q, state_d;
  logic [SEL_W-1:0] lock_q, lock_d;
`endif

  always_comb begin : arbitrate
    int cand;
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    cand       = 0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    in_ready   = '0;
    ptr_d      = ptr_q;
`ifdef COMB_ALWAYS_RR_LOCK_EN
    state_d    = state_q;
    lock_d     = lock_q;
    if (state_q == ST_LOCKED) begin
      // A locked channel that drops valid simply stalls; nobody else may cut in.
      grant_any = in_valid[lock_q];
      grant_idx = lock_q;
    end else
`endif
    begin
      for (int i = 0; i < NUM_CH; i++) begin
        cand = int'(ptr_q) + i;
        if (cand >= NUM_CH) cand -= NUM_CH;
        if (!grant_any && in_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(cand);
        end
      end
    end

    load = !out_valid || out_ready;
    xfer = !rst && load && grant_any;

    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = xfer;
      end
    end

    next_idx = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    if (xfer) begin
`ifdef COMB_ALWAYS_RR_LOCK_EN
      if (in_last[grant_idx]) begin
        state_d = ST_IDLE;
        ptr_d   = next_idx;
      end else begin
        state_d = ST_LOCKED;
        lock_d  = grant_idx;
      end
`else
      ptr_d = next_idx;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_q     <= '0;
`ifdef COMB_ALWAYS_RR_LOCK_EN
      state_q   <= ST_IDLE;
      lock_q    <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
`ifdef COMB_ALWAYS_RR_LOCK_EN
      state_q <= state_d;
      lock_q  <= lock_d;
`endif
      if (load) begin
        if (xfer) begin
          out_valid <= 1'b1;
          out_data  <= grant_data;
          out_sel   <= grant_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_comb_always_rr_select.sv
// Randomised self-checking bench for comb_always_rr_select against a behavioural round-robin model.
// Lock scenario is exercised only when COMB_ALWAYS_RR_LOCK_EN is defined.
module tb_comb_always_rr_select;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [DW-1:0] in_data;
`ifdef COMB_ALWAYS_RR_LOCK_EN
  logic [N-1:0]  in_last;
`endif
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;
  logic          out_ready;

  int total = 0;
  int bad   = 0;

  // Model state: what the output register should hold and where the search starts.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  bit           m_locked;
  int           m_lock;
  logic [N-1:0] exp_ready;
  logic [N-1:0] act_ready;

  comb_always_rr_select #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef COMB_ALWAYS_RR_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_sel    = 0;
    m_ptr    = 0;
    m_locked = 1'b0;
    m_lock   = 0;
  endtask

  function automatic int pick();
    if (m_locked) return in_valid[m_lock] ? m_lock : -1;
    for (int i = 0; i < N; i++) begin
      int c = (m_ptr + i) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: predict in_ready for the current inputs, sample it, advance the model across the edge.
  task automatic step();
    int g;
    bit ld;
    #1;
    ld = !m_valid || out_ready;
    g  = pick();
    exp_ready = '0;
    if (ld && g >= 0) exp_ready[g] = 1'b1;
    act_ready = in_ready;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
`ifdef COMB_ALWAYS_RR_LOCK_EN
        if (in_last[g]) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_lock   = g;
        end
`else
        m_ptr = (g + 1) % N;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = DW'($urandom);
    out_ready = 1'b0;
    #12;
    total++; if (in_ready !== '0) begin bad++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    total++; if (out_sel !== '0) begin bad++; $display("FAIL reset_out_sel got=%0d want=0", out_sel); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    in_data   = 32'h13121110;
    out_ready = 1'b1;
    step();
    total++; if (act_ready !== 4'b0001) begin bad++; $display("FAIL first_grant_ready got=%b want=0001", act_ready); end
    total++; if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL first_grant_sel got=%0d/%b want=0/1", out_sel, out_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    in_valid  = '1;
    in_data   = 32'h13121110;
    out_ready = 1'b1;
    foreach (exp_seq[i]) begin
      step();
      total++; if (out_sel !== 2'(exp_seq[i]) || out_sel !== 2'(m_sel)) begin
        bad++; $display("FAIL rr_sel[%0d] got=%0d want=%0d", i, out_sel, exp_seq[i]);
      end
      total++; if (out_data !== 8'(8'h10 + exp_seq[i]) || out_valid !== 1'b1) begin
        bad++; $display("FAIL rr_data[%0d] got=%h/%b want=%h/1", i, out_data, out_valid, 8'(8'h10 + exp_seq[i]));
      end
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] vseq [4] = '{4'b1000, 4'b1111, 4'b0010, 4'b1111};
    int           sseq [4] = '{3, 0, 1, 2};
    out_ready = 1'b1;
    foreach (vseq[i]) begin
      in_valid = vseq[i];
      step();
      total++; if (out_sel !== 2'(sseq[i]) || out_sel !== 2'(m_sel) || out_data !== m_data) begin
        bad++; $display("FAIL wrap_sel[%0d] got=%0d/%h want=%0d/%h", i, out_sel, out_data, sseq[i], m_data);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] held_data;
    held_data = out_data;
    in_valid  = '1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (act_ready !== '0) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0000", i, act_ready); end
      total++; if (out_sel !== 2'd2 || out_data !== held_data || out_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got=%0d/%h want=2/%h", i, out_sel, out_data, held_data);
      end
    end
    out_ready = 1'b1;
    step();
    total++; if (out_sel !== 2'd3 || act_ready !== 4'b1000) begin
      bad++; $display("FAIL stall_release got=%0d/%b want=3/1000", out_sel, act_ready);
    end
  endtask

  task automatic test_async_reset();
    in_valid  = '1;
    out_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== '0) begin
      bad++; $display("FAIL async_reset got=%b/%b want=0/0000", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_cycle_xfer got=%b want=0", out_valid); end
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    step();
    total++; if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL post_reset_ptr got=%0d/%b want=0/1", out_sel, out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = N'($urandom);
      in_data   = DW'($urandom);
      out_ready = ($urandom % 4) != 0;
`ifdef COMB_ALWAYS_RR_LOCK_EN
      in_last   = N'($urandom);
`endif
      step();
      total++; if (act_ready !== exp_ready) begin
        bad++; $display("FAIL rand_ready[%0d] got=%b want=%b", i, act_ready, exp_ready);
      end
      total++; if (out_valid !== m_valid || out_data !== m_data || out_sel !== 2'(m_sel)) begin
        bad++; $display("FAIL rand_out[%0d] got=%b/%h/%0d want=%b/%h/%0d",
                        i, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
  endtask

`ifdef COMB_ALWAYS_RR_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] lseq [3] = '{4'b1011, 4'b1011, 4'b1111};
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    in_data   = 32'h23222120;
    in_last   = '1;
    in_valid  = 4'b0010;
    step();
    total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL lock_setup got=%0d want=1", out_sel); end
    in_valid = 4'b0111;
    foreach (lseq[i]) begin
      in_last = lseq[i];
      step();
      total++; if (out_sel !== 2'd2 || out_data !== 8'h22 || act_ready !== 4'b0100) begin
        bad++; $display("FAIL lock_beat[%0d] got=%0d/%h/%b want=2/22/0100", i, out_sel, out_data, act_ready);
      end
    end
    in_valid = 4'b0011;
    step();
    total++; if (out_sel !== 2'd0 || out_sel !== 2'(m_sel)) begin
      bad++; $display("FAIL lock_release got=%0d want=0", out_sel);
    end
    in_last = '1;
  endtask
`endif

  initial begin
    model_reset();
`ifdef COMB_ALWAYS_RR_LOCK_EN
    in_last = '1;
`endif
    test_reset();
    test_round_robin();
    test_wrap();
    test_stall();
    test_async_reset();
`ifdef COMB_ALWAYS_RR_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
